// File: rtl/pulse_gen.sv
// -----------------------------------------------------------------------------
// pulse_gen
//   Converts single-cycle triggers into stretched level pulses. Each trigger
//   carries its own high-time (len, 0 treated as 1). Consecutive pulses are
//   separated by at least GAP low cycles. Triggers that arrive while a pulse
//   or its trailing gap is in progress are queued in a small FIFO together
//   with their sampled len, and are launched in arrival order. Triggers that
//   find the queue full are discarded and flagged on drop.
//
//   Optional feature (macro PULSE_GEN_RETRIGGER_EN):
//     when defined, a trigger that arrives during the high phase reloads the
//     high-time counter instead of being queued (the pulse is extended).
//
// Parameters
//   LEN_W : width of the len field
//   GAP   : low cycles forced between pulses (1..255)
//   DEPTH : pending-trigger capacity (power of two, 2..16)
//
// Ports
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   din   : trigger, one event per cycle sampled high
//   len   : requested high-time, sampled with din
//   dout  : registered stretched pulse
//   busy  : FSM active or triggers pending
//   pend  : number of queued triggers
//   drop  : registered one-cycle flag, a trigger was discarded last cycle
// -----------------------------------------------------------------------------
module pulse_gen #(
   parameter int LEN_W = 8,
   parameter int GAP   = 1,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     din,
   input  logic [LEN_W-1:0]         len,
   output logic                     dout,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   pend,
   output logic                     drop
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [7:0]    GAP_LD = 8'(GAP);
   localparam logic [CW-1:0] FULL   = CW'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HIGH = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t           state_r;
   logic [LEN_W-1:0] cnt_r;
   logic [7:0]       gcnt_r;
   logic             dout_r;
   logic             drop_r;
   logic [LEN_W-1:0] mem_r [DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;

   logic [LEN_W-1:0] len_eff_s;
   logic             retrig_s;
   logic             want_push_s;
   logic             gap_end_s;
   logic             bypass_s;
   logic             pop_s;
   logic             push_s;
   logic             drop_s;
   logic [LEN_W-1:0] head_s;

   assign len_eff_s = (len == '0) ? LEN_W'(1) : len;

`ifdef PULSE_GEN_RETRIGGER_EN
   // A trigger during the high phase extends the pulse instead of queueing.
   assign retrig_s = din && (state_r == S_HIGH);
`else
   assign retrig_s = 1'b0;
`endif

   // Any trigger outside IDLE wants a queue slot, unless it retriggers.
   assign want_push_s = din && (state_r != S_IDLE) && !retrig_s;
   assign gap_end_s   = (state_r == S_GAP) && (gcnt_r == 8'd1);
   // Trigger landing on the last gap cycle with an empty queue launches
   // directly, so it never occupies a slot.
   assign bypass_s    = gap_end_s && want_push_s && (count_r == '0);
   assign pop_s       = gap_end_s && (count_r != '0);
   assign push_s      = want_push_s && !bypass_s && (count_r != FULL);
   assign drop_s      = want_push_s && !bypass_s && (count_r == FULL);
   assign head_s      = mem_r[rd_ptr_r];

   assign dout = dout_r;
   assign drop = drop_r;
   assign pend = count_r;
   assign busy = (state_r != S_IDLE) || (count_r != '0);

   // Trigger FIFO: pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         drop_r   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else begin
         drop_r <= drop_s;
         if (push_s) begin
            mem_r[wr_ptr_r] <= len_eff_s;
            wr_ptr_r        <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Pulse FSM: high-time down-counter, then gap down-counter, then relaunch.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= S_IDLE;
         cnt_r   <= '0;
         gcnt_r  <= 8'd0;
         dout_r  <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (din) begin
                  state_r <= S_HIGH;
                  cnt_r   <= len_eff_s;
                  dout_r  <= 1'b1;
               end else begin
                  dout_r  <= 1'b0;
               end
            end
            S_HIGH: begin
               if (retrig_s) begin
                  cnt_r  <= len_eff_s;
                  dout_r <= 1'b1;
               end else if (cnt_r == LEN_W'(1)) begin
                  state_r <= S_GAP;
                  gcnt_r  <= GAP_LD;
                  dout_r  <= 1'b0;
               end else begin
                  cnt_r  <= cnt_r - LEN_W'(1);
                  dout_r <= 1'b1;
               end
            end
            S_GAP: begin
               if (gcnt_r != 8'd1) begin
                  gcnt_r <= gcnt_r - 8'd1;
                  dout_r <= 1'b0;
               end else if (pop_s) begin
                  state_r <= S_HIGH;
                  cnt_r   <= head_s;
                  dout_r  <= 1'b1;
               end else if (bypass_s) begin
                  state_r <= S_HIGH;
                  cnt_r   <= len_eff_s;
                  dout_r  <= 1'b1;
               end else begin
                  state_r <= S_IDLE;
                  dout_r  <= 1'b0;
               end
            end
            default: begin
               state_r <= S_IDLE;
               dout_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_pulse_gen
//   Directed scenarios plus randomized traffic for pulse_gen (GAP=2, DEPTH=4).
//   The reference model tracks pulses as time intervals: the cycle on which
//   the current pulse ends and a queue of pending lengths.
// -----------------------------------------------------------------------------
module tb_pulse_gen;

   localparam int LEN_W = 8;
   localparam int GAP   = 2;
   localparam int DEPTH = 4;
   localparam int PW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             din = 1'b0;
   logic [LEN_W-1:0] len = '0;
   logic             dout;
   logic             busy;
   logic [PW-1:0]    pend;
   logic             drop;

   always #5 clk = ~clk;

   pulse_gen #(.LEN_W(LEN_W), .GAP(GAP), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .din   (din),
      .len   (len),
      .dout  (dout),
      .busy  (busy),
      .pend  (pend),
      .drop  (drop)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // reference model state
   bit m_active   = 1'b0;
   int m_hi_until = 0;
   int m_q[$];
   bit m_drop     = 1'b0;

   int   pulses    = 0;
   int   drops     = 0;
   logic prev_dout = 1'b0;

   int pat36_dout[9] = '{1, 1, 0, 0, 1, 1, 1, 1, 0};
   int pat36_pend[9] = '{0, 1, 1, 1, 0, 0, 0, 0, 0};

   task automatic chk(input string tag, input logic [31:0] got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Advance the model across one clock edge given the inputs of cycle cyc.
   task automatic model_update(input bit r, input bit d, input int l);
      int  eff;
      bit  in_high;
      bit  last_gap;
      bit  full;
      bit  taken;
      eff    = (l == 0) ? 1 : l;
      m_drop = 1'b0;
      if (r) begin
         m_active = 1'b0;
         m_q.delete();
      end else if (!m_active) begin
         if (d) begin
            m_active   = 1'b1;
            m_hi_until = cyc + eff;
         end
      end else begin
         in_high  = (cyc <= m_hi_until);
         last_gap = (cyc == m_hi_until + GAP);
         full     = (m_q.size() == DEPTH);
         taken    = 1'b0;
`ifdef PULSE_GEN_RETRIGGER_EN
         if (d && in_high) begin
            m_hi_until = cyc + eff;
            taken      = 1'b1;
         end
`endif
         if (last_gap) begin
            if (m_q.size() > 0) begin
               m_hi_until = cyc + m_q.pop_front();
            end else if (d) begin
               m_hi_until = cyc + eff;
               taken      = 1'b1;
            end else begin
               m_active = 1'b0;
            end
         end
         if (d && !taken) begin
            if (full) m_drop = 1'b1;
            else      m_q.push_back(eff);
         end
      end
   endtask

   // Drive one cycle of inputs, cross the edge, then compare all outputs.
   task automatic step(input bit r, input bit d, input int l);
      reset = r;
      din   = d;
      len   = l[LEN_W-1:0];
      @(posedge clk);
      model_update(r, d, l);
      cyc++;
      #1;
      chk("dout", dout, (m_active && cyc <= m_hi_until) ? 1 : 0);
      chk("busy", busy, (m_active || m_q.size() > 0) ? 1 : 0);
      chk("pend", pend, m_q.size());
      chk("drop", drop, m_drop ? 1 : 0);
      if (dout === 1'b1 && prev_dout !== 1'b1) pulses++;
      if (drop === 1'b1) drops++;
      prev_dout = dout;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
   endtask

   initial begin
      // reset state
      step(1'b1, 1'b0, 0);
      step(1'b1, 1'b1, 5);
      chk("rst_dout", dout, 0);
      chk("rst_pend", pend, 0);
      chk("rst_busy", busy, 0);

      // first honoured trigger is the first one with reset low
      step(1'b0, 1'b1, 2);
      chk("first_trig", dout, 1);
      idle(6);

      // len=3 trigger at cycle 10 after reset
      step(1'b1, 1'b0, 0);
      idle(9);
      step(1'b0, 1'b1, 3);
      chk("r034_c11", dout, 1);
      step(1'b0, 1'b0, 0); chk("r034_c12", dout, 1);
      step(1'b0, 1'b0, 0); chk("r034_c13", dout, 1);
      step(1'b0, 1'b0, 0); chk("r034_c14", dout, 0); chk("r034_busy14", busy, 1);
      step(1'b0, 1'b0, 0); chk("r034_busy15", busy, 1);
      step(1'b0, 1'b0, 0); chk("r034_busy16", busy, 0);

      // len=0 behaves as a one-cycle pulse
      idle(3);
      step(1'b0, 1'b1, 0);
      chk("r035_on", dout, 1);
      step(1'b0, 1'b0, 0);
      chk("r035_off", dout, 0);
      idle(4);

      // two back-to-back triggers with GAP=2
      step(1'b1, 1'b0, 0);
      for (int i = 0; i < 9; i++) begin
         if (i == 0)      step(1'b0, 1'b1, 2);
         else if (i == 1) step(1'b0, 1'b1, 4);
         else             step(1'b0, 1'b0, 0);
         chk("r036_dout", dout, pat36_dout[i]);
         chk("r036_pend", pend, pat36_pend[i]);
      end
      idle(4);

      // overflow: six long triggers, one dropped, five pulses
      step(1'b1, 1'b0, 0);
      pulses = 0;
      drops  = 0;
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 20);
      chk("r037_drop6", drop, 1);
      chk("r037_pend", pend, 4);
      idle(130);
      chk("r037_pulses", pulses, 5);
      chk("r037_drops", drops, 1);

      // reset mid-pulse with two queued triggers
      step(1'b1, 1'b0, 0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 10);
      chk("r038_pend3", pend, 2);
      step(1'b1, 1'b0, 0);
      chk("r038_dout4", dout, 0);
      chk("r038_pend4", pend, 0);
      pulses = 0;
      idle(40);
      chk("r038_pulses", pulses, 0);

      // trigger during the high phase
      step(1'b1, 1'b0, 0);
      step(1'b0, 1'b1, 4);
      step(1'b0, 1'b0, 0);
      step(1'b0, 1'b1, 4);
`ifdef PULSE_GEN_RETRIGGER_EN
      chk("r039_pend", pend, 0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 0);
         chk("r039_high", dout, 1);
      end
`else
      chk("r039_queued", pend, 1);
`endif
      idle(20);

      // randomized traffic with occasional resets
      step(1'b1, 1'b0, 0);
      for (int i = 0; i < 4000; i++) begin
         step(($urandom_range(0, 299) == 0),
              ($urandom_range(0, 99) < 35),
              int'($urandom_range(0, 12)));
      end
      idle(80);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pulse_gen.md
PULSE_GEN -- requirements
Module: pulse_gen

Interface
REQ-001 Parameter LEN_W, default 8, width of the pulse-length field.
REQ-002 Parameter GAP, default 1, number of low cycles forced between consecutive output pulses (legal range 1..255).
REQ-003 Parameter DEPTH, default 4, number of pending triggers that can be held (power of two, 2..16).
REQ-004 clk  input  1  rising-edge clock, sole clock domain.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 din  input  1  trigger; each cycle sampled high is one trigger event (single-cycle pulses expected, a held level counts once per cycle).
REQ-007 len  input  LEN_W  requested high-time in cycles, sampled together with din.
REQ-008 dout  output  1  registered stretched pulse.
REQ-009 busy  output  1  high whenever the FSM is not IDLE or pending triggers exist.
REQ-010 pend  output  $clog2(DEPTH)+1  number of queued triggers.
REQ-011 drop  output  1  registered single-cycle pulse, one cycle after a trigger was discarded.

Function
REQ-012 The block shall convert single-cycle triggers into level pulses, the inverse of rising-edge pulse detection.
REQ-013 The FSM shall have states IDLE, HIGH and GAP, encoded in a registered state variable.
REQ-014 IDLE: trigger at cycle N -> HIGH, with dout high on cycles N+1 .. N+L, where L = len sampled at N.
REQ-015 len = 0 shall be treated as L = 1.
REQ-016 HIGH: a down-counter loaded with L shall hold dout = 1; on the last HIGH cycle the FSM shall go to GAP.
REQ-017 GAP: dout = 0 for exactly GAP cycles, then the FSM shall pop the queue head and enter HIGH if pend > 0, else enter IDLE.
REQ-018 A trigger arriving in HIGH or GAP (including the last cycle of either state) shall push its sampled len into the FIFO.
REQ-019 Queued pulses shall use the len captured at trigger time, not the len present at launch.
REQ-020 Queued pulses shall launch in arrival order.
REQ-021 The FIFO shall be empty whenever the state is IDLE.
REQ-022 A trigger arriving when pend == DEPTH shall be discarded, leave the FIFO unchanged and assert drop on the next cycle.
REQ-023 A push and a pop in the same cycle shall leave pend unchanged and preserve order.
REQ-024 A push into an empty FIFO on the final GAP cycle shall be popped on that same transition, so the pulse launches with no extra delay.
REQ-025 FIFO pointers shall wrap modulo DEPTH, and pend shall never exceed DEPTH.

Reset
REQ-026 While reset is high at a clock edge the block shall, on that edge, set state = IDLE, dout = 0, drop = 0, pend = 0, clear the counters and empty the FIFO.
REQ-027 Reset asserted mid-pulse shall drop dout to 0 on the next cycle and discard all pending triggers.
REQ-028 A din sampled while reset is high shall be ignored.
REQ-029 The first trigger honoured after reset shall be the one sampled in the first cycle with reset low.

Configuration
REQ-030 Macro PULSE_GEN_RETRIGGER_EN selects the retrigger behaviour.
REQ-031 When PULSE_GEN_RETRIGGER_EN is defined, a trigger in HIGH shall reload the counter with its L: dout stays high continuously through the reload, the trigger is not queued, and drop is not asserted.
REQ-032 When PULSE_GEN_RETRIGGER_EN is defined, triggers in GAP shall be queued per REQ-018.
REQ-033 When PULSE_GEN_RETRIGGER_EN is undefined, all HIGH-state triggers shall be queued per REQ-018.

Verification
REQ-034 Reset, then din=1 with len=3 at cycle 10 -> dout=1 on cycles 11-13, 0 on cycle 14; busy falls after the GAP cycles.
REQ-035 len=0 trigger at cycle 5 -> dout=1 on cycle 6 only.
REQ-036 Macro undefined, GAP=2, triggers at cycles 0 (len 2) and 1 (len 4) -> dout high 1-2, low 3-4, high 5-8; pend=1 on cycles 2-4.
REQ-037 DEPTH=4, len=20, triggers on cycles 0-5 -> four queued, drop=1 on cycle 6 only; exactly five pulses emitted.
REQ-038 reset=1 on cycle 3 during a len=10 pulse with two queued triggers -> dout=0 and pend=0 from cycle 4; no further pulses.
REQ-039 Macro defined, len=4 at cycle 0, len=4 at cycle 2 -> dout continuously high on cycles 1-6, pend stays 0.
